play_ctrl: RTL and testbench

Playback controller for the record/playback audio path. It walks SRAM sample addresses at normal, fast (skip) or slow (hold/interpolate) speed. On each DAC sample tick it emits one 16-bit signed sample to the DAC serializer. It replaces the derived, gated playback clock with a single-clock-domain tick/enable design, taking the same speed controls (ratio-minus-1, normal, slow, interp, pause).

---
 rtl/play_pkg.sv | 44 ++++
 rtl/play_ctrl_if.sv | 36 +++
 rtl/play_interp.sv | 40 ++++
 rtl/play_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_play_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/play_pkg.sv
// Shared constants, FSM encodings and helpers for the playback controller.
// Mode decode gives address step and hold count; recip gives round(4096/r) in Q0.12.
package play_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH0 = 3'd1;
  localparam logic [2:0] ST_FETCH1 = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_PAUSED = 3'd4;

  typedef struct packed {
    logic [3:0] step;
    logic [3:0] hold;
  } mode_t;

  function automatic mode_t mode_decode(input logic normal, input logic slow, input logic [2:0] rm1);
    mode_t m;
    m.step = 4'd1;
    m.hold = 4'd1;
    if (!normal) begin
      if (slow) m.hold = {1'b0, rm1} + 4'd1;
      else      m.step = {1'b0, rm1} + 4'd1;
    end
    return m;
  endfunction

  function automatic logic [12:0] recip(input logic [3:0] r);
    case (r)
      4'd1:    recip = 13'd4096;
      4'd2:    recip = 13'd2048;
      4'd3:    recip = 13'd1365;
      4'd4:    recip = 13'd1024;
      4'd5:    recip = 13'd819;
      4'd6:    recip = 13'd683;
      4'd7:    recip = 13'd585;
      4'd8:    recip = 13'd512;
      default: recip = 13'd4096;
    endcase
  endfunction

endpackage

// File: rtl/play_ctrl_if.sv
// Control, SRAM read and DAC sample signals of the playback controller.
// slave = controller side, master = system/SRAM side.
interface play_ctrl_if;
  import play_pkg::*;

  logic                     i_sample_tick;
  logic                     i_start;
  logic                     i_stop;
  logic                     i_pause;
  logic [2:0]               i_ratio_m1;
  logic                     i_is_normal;
  logic                     i_is_slow;
  logic                     i_interp;
  logic [ADDR_W-1:0]        i_end_addr;
  logic [ADDR_W-1:0]        o_sram_addr;
  logic                     o_sram_rd_req;
  logic                     i_sram_rd_valid;
  logic [DATA_W-1:0]        i_sram_rdata;
  logic [DATA_W-1:0]        o_sample;
  logic                     o_sample_valid;
  logic                     o_busy;
  logic                     o_done;
  logic                     o_underrun;

  modport slave (
    input  i_sample_tick, i_start, i_stop, i_pause, i_ratio_m1, i_is_normal, i_is_slow,
           i_interp, i_end_addr, i_sram_rd_valid, i_sram_rdata,
    output o_sram_addr, o_sram_rd_req, o_sample, o_sample_valid, o_busy, o_done, o_underrun
  );

  modport master (
    output i_sample_tick, i_start, i_stop, i_pause, i_ratio_m1, i_is_normal, i_is_slow,
           i_interp, i_end_addr, i_sram_rd_valid, i_sram_rdata,
    input  o_sram_addr, o_sram_rd_req, o_sample, o_sample_valid, o_busy, o_done, o_underrun
  );
endinterface

// File: rtl/play_interp.sv
// Combinational linear interpolation s0 + (s1-s0)*k*recip(r) >>> 12, saturated to DATA_W.
// No latency; the result is registered by the play_ctrl output stage.
module play_interp
  import play_pkg::*;
(
  input  logic [DATA_W-1:0] s0_i,
  input  logic [DATA_W-1:0] s1_i,
  input  logic [2:0]        k_i,
  input  logic [3:0]        r_i,
  output logic [DATA_W-1:0] sample_o
);

  localparam int PW = DATA_W + 4;
  localparam int QW = DATA_W + 18;

  logic signed [DATA_W:0]   diff;
  logic signed [PW-1:0]     diff_x, k_x, p;
  logic signed [QW-1:0]     p_x, r_x, pr, q;
  logic [DATA_W+5:0]        sum;

  always_comb begin
    diff     = $signed({s1_i[DATA_W-1], s1_i}) - $signed({s0_i[DATA_W-1], s0_i});
    diff_x   = PW'(diff);
    k_x      = PW'($signed({1'b0, k_i}));
    p        = diff_x * k_x;
    p_x      = QW'(p);
    r_x      = QW'($signed({1'b0, recip(r_i)}));
    pr       = p_x * r_x;
    q        = pr >>> 12;
    sum      = {{6{s0_i[DATA_W-1]}}, s0_i} + q[DATA_W+5:0];
    // Saturate whenever the bits above the DATA_W sign bit disagree with it.
    if (sum[DATA_W+5:DATA_W-1] == '0 || sum[DATA_W+5:DATA_W-1] == '1)
      sample_o = sum[DATA_W-1:0];
    else if (sum[DATA_W+5])
      sample_o = {1'b1, {(DATA_W-1){1'b0}}};
    else
      sample_o = {1'b0, {(DATA_W-1){1'b1}}};
  end

endmodule

// File: rtl/play_ctrl.sv
// Tick-driven SRAM playback controller (normal/fast/slow); sample appears 1 cycle after its tick.
// SRAM fetch still outstanding at a tick re-emits the last sample and sets underrun. Macro PLAY_INTERP_EN adds interpolation.
module play_ctrl
  import play_pkg::*;
(
  input  logic       CLK50,
  input  logic       RST,
  play_ctrl_if.slave bus
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, sram_addr_q, sram_addr_d;
  logic [2:0]        k_q, k_d;
  logic [DATA_W-1:0] s0_q, s0_d, sample_q, sample_d, hold_sample;
  mode_t             mode_q, mode_d, mode_in;
  logic              rd_req_q, rd_req_d, pend_q, pend_d;
  logic              vld_q, vld_d, done_q, done_d, under_q, under_d;
  logic [ADDR_W:0]   next_addr;
  logic              at_end, last_adv;

`ifdef PLAY_INTERP_EN
  logic [DATA_W-1:0] s1_q, s1_d, interp_sample;
  logic              interp_q, interp_d, tgt_q, tgt_d, interp_in;

  assign interp_in   = !bus.i_is_normal && bus.i_is_slow && bus.i_interp;
  assign hold_sample = interp_q ? interp_sample : s0_q;

  play_interp u_interp (
    .s0_i     (s0_q),
    .s1_i     (s1_q),
    .k_i      (k_q),
    .r_i      (mode_q.hold),
    .sample_o (interp_sample)
  );
`else
  assign hold_sample = s0_q;
`endif

  assign mode_in   = mode_decode(bus.i_is_normal, bus.i_is_slow, bus.i_ratio_m1);
  assign next_addr = {1'b0, addr_q} + {{(ADDR_W-3){1'b0}}, mode_q.step};
  assign at_end    = next_addr[ADDR_W] || (next_addr[ADDR_W-1:0] > bus.i_end_addr);
  assign last_adv  = ({1'b0, k_q} + 4'd1) == mode_q.hold;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    sram_addr_d = sram_addr_q;
    k_d         = k_q;
    s0_d        = s0_q;
    sample_d    = sample_q;
    mode_d      = mode_q;
    rd_req_d    = 1'b0;
    pend_d      = pend_q;
    vld_d       = 1'b0;
    done_d      = 1'b0;
    under_d     = under_q;
`ifdef PLAY_INTERP_EN
    s1_d        = s1_q;
    interp_d    = interp_q;
    tgt_d       = tgt_q;
`endif
    if (bus.i_stop) begin
      state_d = ST_IDLE;
      pend_d  = 1'b0;
    end else begin
      if (bus.i_sram_rd_valid && pend_q) begin
        pend_d = 1'b0;
`ifdef PLAY_INTERP_EN
        if (tgt_q) s1_d = bus.i_sram_rdata;
        else       s0_d = bus.i_sram_rdata;
        if (!tgt_q && interp_q) begin
          rd_req_d    = 1'b1;
          pend_d      = 1'b1;
          tgt_d       = 1'b1;
          sram_addr_d = addr_q + ADDR_W'(1);
          if (state_q == ST_FETCH0) state_d = ST_FETCH1;
        end else if (state_q == ST_FETCH0 || state_q == ST_FETCH1) begin
          state_d = ST_RUN;
        end
`else
        s0_d = bus.i_sram_rdata;
        if (state_q == ST_FETCH0) state_d = ST_RUN;
`endif
      end

      case (state_q)
        ST_IDLE: begin
          if (bus.i_start) begin
            state_d     = ST_FETCH0;
            addr_d      = '0;
            sram_addr_d = '0;
            k_d         = '0;
            mode_d      = mode_in;
            rd_req_d    = 1'b1;
            pend_d      = 1'b1;
            under_d     = 1'b0;
`ifdef PLAY_INTERP_EN
            interp_d    = interp_in;
            tgt_d       = 1'b0;
`endif
          end
        end
        ST_FETCH0, ST_FETCH1: ;
        ST_RUN: begin
          if (bus.i_pause) begin
            state_d = ST_PAUSED;
          end else if (bus.i_sample_tick) begin
            vld_d = 1'b1;
            if (pend_q) begin
              under_d = 1'b1;
            end else begin
              sample_d = hold_sample;
              if (!last_adv) begin
                k_d = k_q + 3'd1;
              end else if (at_end) begin
                k_d     = '0;
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                // Mode and ratio are only re-latched here, never mid-hold.
                k_d         = '0;
                addr_d      = next_addr[ADDR_W-1:0];
                mode_d      = mode_in;
                rd_req_d    = 1'b1;
                pend_d      = 1'b1;
                sram_addr_d = next_addr[ADDR_W-1:0];
`ifdef PLAY_INTERP_EN
                interp_d    = interp_in;
                tgt_d       = 1'b0;
                if (interp_q && interp_in) begin
                  s0_d        = s1_q;
                  tgt_d       = 1'b1;
                  sram_addr_d = next_addr[ADDR_W-1:0] + ADDR_W'(1);
                end
`endif
              end
            end
          end
        end
        ST_PAUSED: if (!bus.i_pause) state_d = ST_RUN;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK50) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      sram_addr_q <= '0;
      k_q         <= '0;
      s0_q        <= '0;
      sample_q    <= '0;
      mode_q      <= '0;
      rd_req_q    <= 1'b0;
      pend_q      <= 1'b0;
      vld_q       <= 1'b0;
      done_q      <= 1'b0;
      under_q     <= 1'b0;
`ifdef PLAY_INTERP_EN
      s1_q        <= '0;
      interp_q    <= 1'b0;
      tgt_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      sram_addr_q <= sram_addr_d;
      k_q         <= k_d;
      s0_q        <= s0_d;
      sample_q    <= sample_d;
      mode_q      <= mode_d;
      rd_req_q    <= rd_req_d;
      pend_q      <= pend_d;
      vld_q       <= vld_d;
      done_q      <= done_d;
      under_q     <= under_d;
`ifdef PLAY_INTERP_EN
      s1_q        <= s1_d;
      interp_q    <= interp_d;
      tgt_q       <= tgt_d;
`endif
    end
  end

  assign bus.o_sram_addr    = sram_addr_q;
  assign bus.o_sram_rd_req  = rd_req_q;
  assign bus.o_sample       = sample_q;
  assign bus.o_sample_valid = vld_q;
  assign bus.o_busy         = (state_q != ST_IDLE);
  assign bus.o_done         = done_q;
  assign bus.o_underrun     = under_q;

endmodule

// File: tb/tb_play_ctrl.sv
// Scoreboard bench for play_ctrl: expected samples queued at each tick, compared on o_sample_valid.
// SRAM is a behavioural single-outstanding model with programmable latency.
module tb_play_ctrl;
  import play_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  play_ctrl_if bus_if ();

  play_ctrl dut (
    .CLK50 (clk),
    .RST   (rst),
    .bus   (bus_if)
  );

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int done_cnt = 0;
  int sram_lat = 1;
  int sram_cnt = 0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] mem [0:63];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // SRAM model: answers each request after sram_lat cycles
  always @(negedge clk) begin
    bus_if.i_sram_rd_valid = 1'b0;
    if (sram_cnt > 0) begin
      sram_cnt--;
      if (sram_cnt == 0) begin
        bus_if.i_sram_rd_valid = 1'b1;
        bus_if.i_sram_rdata    = mem[rd_addr[5:0]];
      end
    end
    if (bus_if.o_sram_rd_req === 1'b1) begin
      rd_addr  = bus_if.o_sram_addr;
      sram_cnt = sram_lat;
    end
  end

  // Output monitor
  always @(negedge clk) begin
    if (!rst && bus_if.o_sample_valid === 1'b1) begin
      chk("sample_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("sample", int'($signed(bus_if.o_sample)), exp_q.pop_front());
    end
    if (!rst && bus_if.o_done === 1'b1) begin
      done_cnt++;
      chk("busy_low_at_done", int'(bus_if.o_busy), 0);
    end
  end

  task automatic set_mode(input bit normal, input bit slow, input bit interp,
                          input int ratio_m1, input int end_addr);
    bus_if.i_is_normal = normal;
    bus_if.i_is_slow   = slow;
    bus_if.i_interp    = interp;
    bus_if.i_ratio_m1  = 3'(ratio_m1);
    bus_if.i_end_addr  = ADDR_W'(end_addr);
  endtask

  task automatic start_play(input int settle);
    bus_if.i_start = 1'b1;
    @(negedge clk);
    bus_if.i_start = 1'b0;
    repeat (settle) @(negedge clk);
  endtask

  task automatic tick(input bit push, input int v, input int gap);
    if (push) exp_q.push_back(v);
    bus_if.i_sample_tick = 1'b1;
    @(negedge clk);
    bus_if.i_sample_tick = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic finish_run(input string tag, input int done_before);
    int i;
    for (i = 0; i < 200; i++) begin
      if (bus_if.o_busy === 1'b0) break;
      @(negedge clk);
    end
    chk({tag, "_idle"}, int'(bus_if.o_busy), 0);
    repeat (3) @(negedge clk);
    chk({tag, "_done_once"}, done_cnt - done_before, 1);
    chk({tag, "_sb_drained"}, exp_q.size(), 0);
  endtask

  int d0;

  initial begin
    bus_if.i_sample_tick   = 1'b0;
    bus_if.i_start         = 1'b0;
    bus_if.i_stop          = 1'b0;
    bus_if.i_pause         = 1'b0;
    bus_if.i_sram_rd_valid = 1'b0;
    bus_if.i_sram_rdata    = '0;
    set_mode(1'b1, 1'b0, 1'b0, 0, 0);
    for (int a = 0; a < 64; a++) mem[a] = '0;

    repeat (3) @(negedge clk);
    chk("rst_sample", int'(bus_if.o_sample), 0);
    chk("rst_valid", int'(bus_if.o_sample_valid), 0);
    chk("rst_busy", int'(bus_if.o_busy), 0);
    chk("rst_done", int'(bus_if.o_done), 0);
    chk("rst_underrun", int'(bus_if.o_underrun), 0);
    chk("rst_rd_req", int'(bus_if.o_sram_rd_req), 0);
    chk("rst_addr", int'(bus_if.o_sram_addr), 0);
    rst = 1'b0;
    @(negedge clk);

    // Normal mode, five samples then end
    for (int a = 0; a < 5; a++) mem[a] = DATA_W'(100 * (a + 1));
    set_mode(1'b1, 1'b0, 1'b0, 0, 4);
    sram_lat = 1;
    d0 = done_cnt;
    bus_if.i_start = 1'b1;
    @(negedge clk);
    bus_if.i_start = 1'b0;
    chk("rd_req_after_start", int'(bus_if.o_sram_rd_req), 1);
    chk("rd_addr_after_start", int'(bus_if.o_sram_addr), 0);
    chk("busy_after_start", int'(bus_if.o_busy), 1);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 5; i++) tick(1'b1, 100 * (i + 1), 4);
    finish_run("normal", d0);

    // Fast mode r=3: addresses 0,3,6,9
    for (int a = 0; a < 16; a++) mem[a] = DATA_W'(10 * a + 7);
    set_mode(1'b0, 1'b0, 1'b0, 2, 9);
    d0 = done_cnt;
    start_play(6);
    for (int i = 0; i < 4; i++) tick(1'b1, 30 * i + 7, 4);
    finish_run("fast", d0);

    // Slow r=4 with interpolation request, two pairs
    mem[0] = 16'd0; mem[1] = 16'd400; mem[2] = 16'd800;
    set_mode(1'b0, 1'b1, 1'b1, 3, 1);
    d0 = done_cnt;
    start_play(10);
    for (int i = 0; i < 8; i++) begin
`ifdef PLAY_INTERP_EN
      tick(1'b1, 100 * i, 4);
`else
      tick(1'b1, (i < 4) ? 0 : 400, 4);
`endif
    end
    finish_run("slow_r4", d0);

    // Slow r=2 across full-scale swing
    mem[0] = 16'h7fff; mem[1] = 16'h8000;
    set_mode(1'b0, 1'b1, 1'b1, 1, 0);
    d0 = done_cnt;
    start_play(10);
    tick(1'b1, 32767, 4);
`ifdef PLAY_INTERP_EN
    tick(1'b1, -1, 4);
`else
    tick(1'b1, 32767, 4);
`endif
    finish_run("slow_r2_sat", d0);

    // Pause for 10 ticks mid-run
    for (int a = 0; a < 8; a++) mem[a] = DATA_W'(1000 + a);
    set_mode(1'b1, 1'b0, 1'b0, 0, 7);
    d0 = done_cnt;
    start_play(6);
    for (int i = 0; i < 3; i++) tick(1'b1, 1000 + i, 4);
    bus_if.i_pause = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) tick(1'b0, 0, 3);
    chk("busy_in_pause", int'(bus_if.o_busy), 1);
    bus_if.i_pause = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 3; i < 8; i++) tick(1'b1, 1000 + i, 4);
    finish_run("pause", d0);

    // Slow SRAM: underrun repeat, then stop during a fetch
    for (int a = 0; a < 8; a++) mem[a] = DATA_W'(2000 + a);
    set_mode(1'b1, 1'b0, 1'b0, 0, 20);
    sram_lat = 8;
    d0 = done_cnt;
    start_play(15);
    tick(1'b1, 2000, 1);
    tick(1'b1, 2000, 1);
    chk("underrun_set", int'(bus_if.o_underrun), 1);
    repeat (12) @(negedge clk);
    tick(1'b1, 2001, 2);
    bus_if.i_stop = 1'b1;
    @(negedge clk);
    bus_if.i_stop = 1'b0;
    chk("stop_idle", int'(bus_if.o_busy), 0);
    repeat (12) @(negedge clk);
    chk("stop_still_idle", int'(bus_if.o_busy), 0);
    chk("underrun_sticky", int'(bus_if.o_underrun), 1);
    chk("stop_no_done", done_cnt - d0, 0);
    chk("stop_sb_drained", exp_q.size(), 0);

    // Restart clears underrun
    sram_lat = 1;
    set_mode(1'b1, 1'b0, 1'b0, 0, 0);
    d0 = done_cnt;
    start_play(0);
    chk("underrun_cleared", int'(bus_if.o_underrun), 0);
    repeat (6) @(negedge clk);
    tick(1'b1, 2000, 4);
    finish_run("restart", d0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
